// File: rtl/spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// spi_cmd_ctrl : SPI command/data sequencer for config, GPIO and status regs
// Rev 1.0
// ============================================================================
module spi_cmd_ctrl #(
    parameter int         TIMEOUT  = 1024,
    parameter logic [7:0] ID_VALUE = 8'hA5,
    parameter logic [7:0] MODE_RST = 8'h00
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic [7:0] gpio_oe,
    output logic [7:0] mode,
    output logic       soft_rst,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_WDATA = 2'd1,
        S_RDATA = 2'd2
    } state_t;

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [3:0]  r_addr;
    logic [15:0] r_cnt;
    logic [1:0]  r_status;
    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;

    logic        w_cmd;
    logic        w_rd_cmd;
    logic        w_wr_commit;
    logic        w_wr_err;
    logic        w_rd_err;
    logic        w_expire;
    logic        w_stat_clr;
    logic [7:0]  w_rd_data;

    // Read mux is addressed straight from the incoming command byte
    always_comb begin
        w_rd_data = 8'h00;
        w_rd_err  = 1'b0;
        case (rx_data[3:0])
            4'h1:    w_rd_data = mode;
            4'h2:    w_rd_data = gpio_out;
            4'h3:    w_rd_data = gpio_oe;
            4'h4:    w_rd_data = r_sync2;
            4'h5:    w_rd_data = {6'b0, r_status};
            4'hF:    w_rd_data = ID_VALUE;
            default: w_rd_err  = 1'b1;
        endcase
    end

    assign w_cmd       = (r_state == S_CMD) && rx_valid;
    assign w_rd_cmd    = w_cmd && !rx_data[7];
    assign w_wr_commit = (r_state == S_WDATA) && rx_valid;
    assign w_wr_err    = w_wr_commit && (r_addr > 4'h3);
    assign w_expire    = (r_state != S_CMD) && !rx_valid && (r_cnt == c_tmo_last);
    assign w_stat_clr  = w_rd_cmd && (rx_data[3:0] == 4'h5);
    assign busy        = (r_state != S_CMD);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_CMD;
            r_addr   <= 4'h0;
            r_cnt    <= 16'h0;
            r_status <= 2'b00;
            r_sync1  <= 8'h00;
            r_sync2  <= 8'h00;
            tx_data  <= 8'h00;
            tx_load  <= 1'b0;
            gpio_out <= 8'h00;
            gpio_oe  <= 8'h00;
            mode     <= MODE_RST;
            soft_rst <= 1'b0;
        end else begin
            tx_load  <= 1'b0;
            soft_rst <= 1'b0;
            r_sync1  <= gpio_in;
            r_sync2  <= r_sync1;

            if (soft_rst) begin
                mode     <= MODE_RST;
                gpio_out <= 8'h00;
                gpio_oe  <= 8'h00;
            end

            // Clear-on-read first, then OR in new events so a coincident set wins
            r_status <= (w_stat_clr ? 2'b00 : r_status)
                      | {w_expire, w_rd_err & w_rd_cmd | w_wr_err};

            if (rx_valid || w_expire)
                r_cnt <= 16'h0;
            else if (r_state != S_CMD)
                r_cnt <= r_cnt + 16'h1;

            case (r_state)
                S_CMD: begin
                    if (rx_valid) begin
                        r_addr <= rx_data[3:0];
                        if (rx_data[7]) begin
                            r_state <= S_WDATA;
                        end else begin
                            r_state <= S_RDATA;
                            tx_data <= w_rd_data;
                            tx_load <= 1'b1;
                        end
                    end
                end
                S_WDATA: begin
                    if (rx_valid) begin
                        r_state <= S_CMD;
                        case (r_addr)
                            4'h0:    soft_rst <= rx_data[0];
                            4'h1:    mode     <= rx_data;
                            4'h2:    gpio_out <= rx_data;
                            4'h3:    gpio_oe  <= rx_data;
                            default: ;
                        endcase
                    end else if (w_expire) begin
                        r_state <= S_CMD;
                    end
                end
                S_RDATA: begin
                    if (rx_valid || w_expire)
                        r_state <= S_CMD;
                end
                default: r_state <= S_CMD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer between the SPI byte slave and the chip's configuration/GPIO resources. It consumes received SPI bytes as command/data pairs, decodes them, commits register writes, and stages read data for the slave to shift out on the next byte. It also owns the mode register, GPIO output/direction registers, the GPIO input synchronizer, sticky error status and a self-clearing soft reset. It sits in the top level between the SPI shift engine and the io pads.

## Interface
Parameters:
- TIMEOUT, 1024: sys_clk cycles allowed between a command byte and its data byte (range 2..65535).
- ID_VALUE, 8'hA5: value returned by reads of address 0xF.
- MODE_RST, 8'h00: reset value of the MODE register.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle pulse; rx_data holds a complete received byte.
- rx_data  in  8  received SPI byte.
- tx_data  out  8  byte for the slave to shift out on the next transfer.
- tx_load  out  1  one-cycle pulse; the slave captures tx_data.
- gpio_in  in  8  asynchronous pad inputs.
- gpio_out  out  8  GPIO_OUT register.
- gpio_oe  out  8  GPIO_DIR register (1 = output).
- mode  out  8  MODE register.
- soft_rst  out  1  one-cycle soft reset pulse.
- busy  out  1  high whenever state is not S_CMD.

## Operation
- Command byte format: bit7 = 1 for write, 0 for read; bits[6:4] ignored; bits[3:0] = address.
- Address map:
  - 0x0 CTRL: write-only. Writing data bit0 = 1 fires soft_rst.
  - 0x1 MODE: R/W.
  - 0x2 GPIO_OUT: R/W.
  - 0x3 GPIO_DIR: R/W.
  - 0x4 GPIO_IN: read-only; returns the synchronized value.
  - 0x5 STATUS: read-only. bit0 = err_addr, bit1 = timeout, other bits 0. Read-to-clear.
  - 0xF ID: read-only; returns ID_VALUE.
  - All other addresses are unmapped.
- Write rules:
  - Writes to a read-only address (0x4, 0x5, 0xF) are ignored and set err_addr.
  - Writes to unmapped addresses are ignored and set err_addr.
- Read rules:
  - Reads of unmapped addresses, or of CTRL, return 0x00 and set err_addr.
- State machine:
  - S_CMD: on rx_valid, latch the address.
    - Write command → S_WDATA.
    - Read command → S_RDATA; load tx_data with the register value and pulse tx_load on the next cycle.
  - S_WDATA: on rx_valid, commit rx_data to the addressed register → S_CMD.
  - S_RDATA: on rx_valid, discard the dummy byte clocked in while read data shifted out → S_CMD.
- Timeout: a counter clears on every rx_valid and counts in S_WDATA and S_RDATA. When it reaches TIMEOUT−1:
  - return to S_CMD;
  - set the timeout bit;
  - perform no write.
- Soft reset clears MODE to MODE_RST, and GPIO_OUT and GPIO_DIR to 0x00. It does not clear STATUS, the FSM or tx_data.
- gpio_in passes through a 2-flop synchronizer before being read.

## Timing
- Reset values:
  - tx_data = 0x00, tx_load = 0
  - mode = MODE_RST
  - gpio_out = 0x00, gpio_oe = 0x00
  - soft_rst = 0, busy = 0
  - STATUS = 0x00, state = S_CMD
  - synchronizer flops = 0
- Write latency: the register output changes on the first rising edge after the data-byte rx_valid cycle.
- CTRL write: soft_rst is high for exactly that one cycle. Register clearing is visible the following cycle.
- Read latency: tx_data and tx_load are registered on the first edge after the command rx_valid. tx_load is high for one cycle. tx_data holds its value until the next load.
- GPIO_IN read returns pad state from at least 2 cycles earlier.
- STATUS read: the value is captured into tx_data, then STATUS clears on the same edge.
  - If an error event occurs in the same cycle as the clearing read, the bit stays set (set wins).
- busy rises the cycle after the command rx_valid and falls the cycle after the data/dummy rx_valid or the timeout.
- rx_valid and timeout expiry in the same cycle: rx_valid wins. The write commits and the timeout bit is not set.
- rx_valid is ignored on the cycle immediately after an internal transition only if it is not a new pulse. Every rx_valid pulse is consumed exactly once; back-to-back pulses on consecutive cycles are legal.
- rst_n asserted mid-transaction: everything returns to reset values immediately; there is no partial write.

## Test plan
- Write MODE: bytes 0x81, 0x10 → mode = 0x10 one cycle after the second rx_valid; busy high for the interval between the bytes.
- GPIO: write 0x82/0xAA and 0x83/0x0F → gpio_out = 0xAA, gpio_oe = 0x0F. Drive gpio_in = 0x3C, wait 3 cycles, send read 0x04 → tx_load pulse with tx_data = 0x3C. The dummy byte 0xFF causes no register change.
- ID and error path:
  - Read 0x0F → tx_data = 0xA5.
  - Write 0x8C/0x55 → no register changes.
  - Read 0x05 → tx_data = 0x01.
  - Read 0x05 again → tx_data = 0x00.
- Timeout with TIMEOUT = 16: send 0x81 and no data → busy drops after 16 cycles and mode is unchanged. A later read of 0x05 returns 0x02. A data byte arriving exactly at expiry commits and leaves STATUS = 0x00.
- Soft reset: with mode = 0x10 and gpio_out = 0xAA, write 0x80/0x01 → soft_rst pulses for 1 cycle, then mode = MODE_RST and gpio_out = 0x00.
- Async reset: assert rst_n low between 0x82 and its data byte → all outputs return to reset values. After release, the byte 0x55 is decoded as a command (a read of address 5), not as write data.
